// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit turning byte/half/word ops into whole-word big-endian DM accesses.
module mem_lsu #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        fault,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_read,
  output logic        dm_write,
  input  logic [31:0] dm_rdata
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state;
  logic [31:0] mergeBuf, wordAddr, lane, mask, merged, loadVal;
  logic [4:0] shamt;
  logic bad, go, isWord;
  always_comb begin
    isWord = req_size == 2'b10;
    bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
          (isWord && req_addr[1:0] != 2'b00) || req_addr >= 32'(MEM_BYTES);
    go = rst_n && state == IDLE && req_valid && !bad;
    // big-endian: lower offsets live in higher bits, so the shift is the inverted offset
    shamt = req_size[0] ? {~req_addr[1], 4'b0} : {~req_addr[1:0], 3'b0};
    lane = dm_rdata >> shamt;
    mask = (req_size[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
    merged = (dm_rdata & ~mask) | ((req_wdata << shamt) & mask);
    loadVal = isWord ? dm_rdata :
              req_size[0] ? {{16{lane[15] & ~req_unsigned}}, lane[15:0]} :
                            {{24{lane[7] & ~req_unsigned}}, lane[7:0]};
    stall = go && req_store && !isWord;
    dm_read = go && (!req_store || !isWord);
    dm_write = rst_n && (state == WRITE || (go && req_store && isWord));
    dm_addr = state == WRITE ? wordAddr : {req_addr[31:2], 2'b00};
    dm_wdata = state == WRITE ? mergeBuf : req_wdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      res_valid <= 1'b0;
      res_data <= '0;
      fault <= 1'b0;
      mergeBuf <= '0;
      wordAddr <= '0;
    end else begin
      fault <= state == IDLE && req_valid && bad;
      res_valid <= go && !req_store;
      if (go && !req_store) res_data <= loadVal;
      if (stall) begin
        mergeBuf <= merged;
        wordAddr <= dm_addr;
      end
      state <= stall ? WRITE : IDLE;
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: table-driven check of mem_lsu against a falling-edge big-endian word memory.
module tb_mem_lsu;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_store = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0, dm_rdata = '0;
  logic stall, res_valid, fault, dm_read, dm_write;
  logic [31:0] res_data, dm_addr, dm_wdata;
  logic [31:0] mem [32] = '{4: 32'h8899AABB, default: 32'h0};
  int applied = 0, miscompares = 0;

  mem_lsu #(.MEM_BYTES(128)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .res_valid(res_valid), .res_data(res_data),
    .fault(fault), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_read(dm_read),
    .dm_write(dm_write), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (dm_read) dm_rdata <= mem[dm_addr[6:2]];
    else if (dm_write) mem[dm_addr[6:2]] <= dm_wdata;

  typedef struct {
    logic v, st;
    logic [1:0] sz;
    logic u;
    logic [31:0] a, wd;
    logic eStall, eRd, eWr;
    logic [31:0] eWd;
    logic eRv;
    logic [31:0] eRes;
    logic eFault;
  } vec_t;

  function automatic vec_t mk(input logic v, st, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, wd, input logic eStall, eRd, eWr,
                              input logic [31:0] eWd, input logic eRv,
                              input logic [31:0] eRes, input logic eFault);
    mk = '{v, st, sz, u, a, wd, eStall, eRd, eWr, eWd, eRv, eRes, eFault};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, st, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, wd);
    req_valid = v; req_store = st; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
  endtask

  task automatic step(input vec_t t);
    applied++;
    drive(t.v, t.st, t.sz, t.u, t.a, t.wd);
    #1;
    chk($sformatf("v%0d.stall", applied), 32'(stall), 32'(t.eStall));
    chk($sformatf("v%0d.dm_read", applied), 32'(dm_read), 32'(t.eRd));
    chk($sformatf("v%0d.dm_write", applied), 32'(dm_write), 32'(t.eWr));
    if (t.eWr) chk($sformatf("v%0d.dm_wdata", applied), dm_wdata, t.eWd);
    @(posedge clk); #1;
    chk($sformatf("v%0d.res_valid", applied), 32'(res_valid), 32'(t.eRv));
    chk($sformatf("v%0d.res_data", applied), res_data, t.eRes);
    chk($sformatf("v%0d.fault", applied), 32'(fault), 32'(t.eFault));
  endtask

  initial begin
    vec_t vq[$];
    //                v  st sz     u  addr    wdata         stl rd wr wdata         rv res_data      flt
    vq.push_back(mk(0, 0, 2'b00, 0, 32'h00, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0));
    vq.push_back(mk(1, 0, 2'b10, 0, 32'h10, 32'h0,        0, 1, 0, 32'h0,        1, 32'h8899AABB, 0));
    vq.push_back(mk(1, 0, 2'b00, 0, 32'h11, 32'h0,        0, 1, 0, 32'h0,        1, 32'hFFFFFF99, 0));
    vq.push_back(mk(1, 0, 2'b00, 1, 32'h11, 32'h0,        0, 1, 0, 32'h0,        1, 32'h00000099, 0));
    vq.push_back(mk(1, 0, 2'b01, 0, 32'h12, 32'h0,        0, 1, 0, 32'h0,        1, 32'hFFFFAABB, 0));
    vq.push_back(mk(1, 0, 2'b01, 1, 32'h10, 32'h0,        0, 1, 0, 32'h0,        1, 32'h00008899, 0));
    vq.push_back(mk(0, 0, 2'b00, 0, 32'h10, 32'h0,        0, 0, 0, 32'h0,        0, 32'h00008899, 0));
    vq.push_back(mk(1, 1, 2'b00, 0, 32'h13, 32'h123456CC, 1, 1, 0, 32'h0,        0, 32'h00008899, 0));
    vq.push_back(mk(1, 1, 2'b00, 0, 32'h13, 32'h123456CC, 0, 0, 1, 32'h8899AACC, 0, 32'h00008899, 0));
    vq.push_back(mk(1, 0, 2'b10, 0, 32'h10, 32'h0,        0, 1, 0, 32'h0,        1, 32'h8899AACC, 0));
    vq.push_back(mk(1, 1, 2'b01, 0, 32'h11, 32'hFFFF,     0, 0, 0, 32'h0,        0, 32'h8899AACC, 1));
    vq.push_back(mk(1, 0, 2'b10, 0, 32'h12, 32'h0,        0, 0, 0, 32'h0,        0, 32'h8899AACC, 1));
    vq.push_back(mk(1, 0, 2'b10, 0, 32'h80, 32'h0,        0, 0, 0, 32'h0,        0, 32'h8899AACC, 1));
    vq.push_back(mk(1, 0, 2'b11, 0, 32'h10, 32'h0,        0, 0, 0, 32'h0,        0, 32'h8899AACC, 1));
    vq.push_back(mk(0, 0, 2'b00, 0, 32'h10, 32'h0,        0, 0, 0, 32'h0,        0, 32'h8899AACC, 0));
    vq.push_back(mk(1, 0, 2'b10, 0, 32'h10, 32'h0,        0, 1, 0, 32'h0,        1, 32'h8899AACC, 0));
    vq.push_back(mk(1, 1, 2'b10, 0, 32'h10, 32'h8899AABB, 0, 0, 1, 32'h8899AABB, 0, 32'h8899AACC, 0));
    vq.push_back(mk(1, 1, 2'b10, 0, 32'h7C, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 0, 32'h8899AACC, 0));
    vq.push_back(mk(1, 0, 2'b10, 0, 32'h7C, 32'h0,        0, 1, 0, 32'h0,        1, 32'hDEADBEEF, 0));
    vq.push_back(mk(1, 1, 2'b01, 0, 32'h12, 32'h0000BEEF, 1, 1, 0, 32'h0,        0, 32'hDEADBEEF, 0));
    vq.push_back(mk(1, 1, 2'b01, 0, 32'h12, 32'h0000BEEF, 0, 0, 1, 32'h8899BEEF, 0, 32'hDEADBEEF, 0));
    vq.push_back(mk(1, 0, 2'b01, 1, 32'h12, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0000BEEF, 0));
    vq.push_back(mk(1, 1, 2'b10, 0, 32'h10, 32'h8899AABB, 0, 0, 1, 32'h8899AABB, 0, 32'h0000BEEF, 0));

    // reset state, with a request present to confirm the enables are gated
    drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
    #2;
    chk("rst.dm_read", 32'(dm_read), 32'h0);
    chk("rst.dm_write", 32'(dm_write), 32'h0);
    chk("rst.stall", 32'(stall), 32'h0);
    chk("rst.res_valid", 32'(res_valid), 32'h0);
    chk("rst.res_data", res_data, 32'h0);
    chk("rst.fault", 32'(fault), 32'h0);
    #5;
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vq[i]) step(vq[i]);

    // reset asserted while the merged half-word is waiting in WRITE
    applied++;
    drive(1, 1, 2'b01, 0, 32'h10, 32'h0000BEEF);
    #1;
    chk("rw.stall", 32'(stall), 32'h1);
    @(posedge clk); #1;
    chk("rw.write", 32'(dm_write), 32'h1);
    chk("rw.wdata", dm_wdata, 32'hBEEFAABB);
    chk("rw.addr", dm_addr, 32'h10);
    rst_n = 1'b0;
    #1;
    chk("rw.write_rst", 32'(dm_write), 32'h0);
    chk("rw.read_rst", 32'(dm_read), 32'h0);
    chk("rw.stall_rst", 32'(stall), 32'h0);
    chk("rw.res_valid_rst", 32'(res_valid), 32'h0);
    chk("rw.res_data_rst", res_data, 32'h0);
    chk("rw.fault_rst", 32'(fault), 32'h0);
    @(posedge clk); #1;
    chk("rw.mem_kept", mem[4], 32'h8899AABB);
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    rst_n = 1'b1;
    step(mk(0, 0, 2'b00, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    step(mk(1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 1, 0, 32'h0, 1, 32'h8899AABB, 0));
    step(mk(0, 0, 2'b00, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 0, 32'h8899AABB, 0));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
